// File: rtl/sccb_pkg.sv
// Shared types and sizing constants for the SCCB write engine.
package sccb_pkg;

    typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP} sccb_state_t;

    localparam int PHASES = 4;
    localparam int BYTES  = 3;
    localparam int BITS   = 8;

endpackage

// File: rtl/sccb_write_master.sv
// Three-byte SCCB/I2C write engine (device, register, data). Each 400 kHz
// tick advances one quarter-bit phase, giving a 100 kHz SCL. All bus
// outputs are registered; their levels are decoded from the next state so
// they change on the same edge as the state/phase they belong to.
module sccb_write_master
    import sccb_pkg::*;
#(
    parameter bit CHECK_ACK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_400kHz,
    input  logic       start,
    input  logic [7:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    input  logic       sda_in,
    output logic       scl,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);
    localparam logic [1:0] LAST_BYTE  = 2'(BYTES - 1);
    localparam logic [2:0] MSB_IDX    = 3'(BITS - 1);

    sccb_state_t     state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [2:0][7:0] data_q, data_d;
    logic            nack_q, nack_d;
    logic            ack_err_d, busy_d, done_d;
    logic            scl_d, sda_oe_d;
    logic [7:0]      cur_byte;

    // Sequencing, then decode of the next phase into (scl, sda_oe) for the output registers
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        data_d     = data_q;
        nack_d     = nack_q;
        ack_err_d  = ack_err;
        busy_d     = busy;
        done_d     = 1'b0;
        scl_d      = 1'b1;
        sda_oe_d   = 1'b0;
        cur_byte   = '0;

        if (state_q == IDLE) begin
            // A tick coincident with start is consumed by acceptance only.
            if (start) begin
                state_d    = START;
                phase_d    = '0;
                bit_idx_d  = MSB_IDX;
                byte_idx_d = '0;
                data_d     = {wr_data, reg_addr, dev_addr};
                nack_d     = 1'b0;
                ack_err_d  = 1'b0;
                busy_d     = 1'b1;
            end
        end else if (tick_400kHz) begin
            phase_d = phase_q + 2'd1;
            if (state_q == ACK && phase_q == 2'd2) begin
                nack_d = sda_in;
            end
            if (phase_q == LAST_PHASE) begin
                case (state_q)
                    START: begin
                        state_d   = BYTE;
                        bit_idx_d = MSB_IDX;
                    end
                    BYTE: begin
                        if (bit_idx_q == '0) begin
                            state_d = ACK;
                        end else begin
                            bit_idx_d = bit_idx_q - 3'd1;
                        end
                    end
                    ACK: begin
                        if (nack_q && CHECK_ACK) begin
                            ack_err_d = 1'b1;
                            state_d   = STOP;
                        end else if (byte_idx_q == LAST_BYTE) begin
                            state_d = STOP;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            bit_idx_d  = MSB_IDX;
                            state_d    = BYTE;
                        end
                    end
                    STOP: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                    default: begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                endcase
            end
        end

        case (byte_idx_d)
            2'd0:    cur_byte = data_d[0];
            2'd1:    cur_byte = data_d[1];
            default: cur_byte = data_d[2];
        endcase

        case (state_d)
            START: begin
                scl_d    = (phase_d != 2'd3);
                sda_oe_d = (phase_d != 2'd0);
            end
            BYTE: begin
                scl_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_oe_d = ~cur_byte[bit_idx_d];
            end
            ACK: begin
                scl_d    = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_oe_d = 1'b0;
            end
            STOP: begin
                scl_d    = (phase_d != 2'd0);
                sda_oe_d = (phase_d == 2'd0) || (phase_d == 2'd1);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    // State, counters and registered bus outputs; reset releases the bus without a STOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            data_q     <= '0;
            nack_q     <= 1'b0;
            scl        <= 1'b1;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            data_q     <= data_d;
            nack_q     <= nack_d;
            scl        <= scl_d;
            sda_oe     <= sda_oe_d;
            busy       <= busy_d;
            done       <= done_d;
            ack_err    <= ack_err_d;
        end
    end

endmodule

// File: tb/tb_sccb_write_master.sv
// Bench for sccb_write_master: two instances (CHECK_ACK=1 with a slave
// model on the bus, CHECK_ACK=0 with SDA left floating high), an expected
// per-phase waveform list built from the latched bytes, and directed
// transactions with hand-computed lengths and received bytes.
module tb_sccb_write_master;

    localparam int TICK_DIV  = 10;
    localparam int CYC_LIMIT = 3000;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       tick      = 1'b0;
    logic       start     = 1'b0;
    logic [7:0] dev_addr  = '0;
    logic [7:0] reg_addr  = '0;
    logic [7:0] wr_data   = '0;
    logic [2:0] nack_mask = '0;
    logic       slave_low = 1'b0;
    logic [1:0] scl_o, oe_o, busy_o, done_o, err_o;
    logic       sda_bus, sda_nc;

    int checks = 0;
    int passes = 0;

    assign sda_bus = ~(oe_o[0] | slave_low);
    assign sda_nc  = ~oe_o[1];

    sccb_write_master #(.CHECK_ACK(1'b1)) dut_chk (
        .clk(clk), .reset(reset), .tick_400kHz(tick), .start(start),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .sda_in(sda_bus), .scl(scl_o[0]), .sda_oe(oe_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .ack_err(err_o[0])
    );

    sccb_write_master #(.CHECK_ACK(1'b0)) dut_nochk (
        .clk(clk), .reset(reset), .tick_400kHz(tick), .start(start),
        .dev_addr(dev_addr), .reg_addr(reg_addr), .wr_data(wr_data),
        .sda_in(sda_nc), .scl(scl_o[1]), .sda_oe(oe_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .ack_err(err_o[1])
    );

    always #5 clk = ~clk;

    // Tick strobe, updated just after the falling edge so it is stable at both edges
    int tdiv = 0;
    always @(negedge clk) begin
        #1;
        tick = (tdiv == TICK_DIV - 1);
        tdiv = (tdiv == TICK_DIV - 1) ? 0 : tdiv + 1;
    end

    // Expected-waveform model: a list of {scl, sda_oe} per tick slot
    logic [1:0] m_seq [2][128];
    logic [1:0] m_active = '0;
    logic [1:0] m_done   = '0;
    logic [1:0] m_err    = '0;
    logic [1:0] m_fail   = '0;
    int         m_idx [2];
    int         m_len [2];
    int         m_stop[2];
    logic [7:0] bb [3];
    int         nb, k;
    logic       o;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_active = '0;
            m_done   = '0;
            m_err    = '0;
        end else begin
            for (int m = 0; m < 2; m++) begin
                m_done[m] = 1'b0;
                if (m_active[m]) begin
                    if (tick) begin
                        m_idx[m]++;
                        if (m_fail[m] && m_idx[m] == m_stop[m]) m_err[m] = 1'b1;
                        if (m_idx[m] == m_len[m]) begin
                            m_active[m] = 1'b0;
                            m_done[m]   = 1'b1;
                        end
                    end
                end else if (start) begin
                    bb[0] = dev_addr;
                    bb[1] = reg_addr;
                    bb[2] = wr_data;
                    nb = 3;
                    m_fail[m] = 1'b0;
                    for (int b = 2; b >= 0; b--) begin
                        if (m == 0 && nack_mask[b]) begin
                            nb = b + 1;
                            m_fail[m] = 1'b1;
                        end
                    end
                    m_seq[m][0] = 2'b10;
                    m_seq[m][1] = 2'b11;
                    m_seq[m][2] = 2'b11;
                    m_seq[m][3] = 2'b01;
                    k = 4;
                    for (int b = 0; b < nb; b++) begin
                        for (int i = 7; i >= 0; i--) begin
                            o = ~bb[b][i];
                            m_seq[m][k]   = {1'b0, o};
                            m_seq[m][k+1] = {1'b1, o};
                            m_seq[m][k+2] = {1'b1, o};
                            m_seq[m][k+3] = {1'b0, o};
                            k = k + 4;
                        end
                        m_seq[m][k]   = 2'b00;
                        m_seq[m][k+1] = 2'b10;
                        m_seq[m][k+2] = 2'b10;
                        m_seq[m][k+3] = 2'b00;
                        k = k + 4;
                    end
                    m_stop[m]     = k;
                    m_seq[m][k]   = 2'b01;
                    m_seq[m][k+1] = 2'b11;
                    m_seq[m][k+2] = 2'b10;
                    m_seq[m][k+3] = 2'b10;
                    m_len[m]      = k + 4;
                    m_active[m]   = 1'b1;
                    m_idx[m]      = 0;
                    m_err[m]      = 1'b0;
                end
            end
        end
    end

    // Slave on instance 0: detects START/STOP, shifts bits at SCL rise, ACKs unless masked
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         rise = 0, byte_no = 0, rx_n = 0, start_seen = 0, stop_seen = 0;
    logic [7:0] shreg = '0;
    logic [7:0] rx_b [4];

    always @(negedge clk) begin
        if (prev_scl && scl_o[0] && prev_sda && !sda_bus) begin
            start_seen++;
            rise = 0; byte_no = 0; rx_n = 0; slave_low = 1'b0;
        end else if (prev_scl && scl_o[0] && !prev_sda && sda_bus) begin
            stop_seen++;
            rise = 0;
        end else if (!prev_scl && scl_o[0]) begin
            rise++;
            if (rise <= 8) shreg = {shreg[6:0], sda_bus};
        end else if (prev_scl && !scl_o[0]) begin
            if (rise == 8) begin
                slave_low = !(byte_no < 3 && nack_mask[byte_no]);
            end else if (rise == 9) begin
                slave_low = 1'b0;
                if (rx_n < 4) rx_b[rx_n] = shreg;
                rx_n++;
                byte_no++;
                rise = 0;
            end
        end
        prev_scl = scl_o[0];
        prev_sda = sda_bus;
    end

    // Transaction monitor: ticks from acceptance to done, cycles to the first tick, done count
    logic [1:0] prev_busy = '0;
    logic [1:0] last_err  = '0;
    int tcnt[2], cyc[2], first_tick[2], last_len[2], done_cnt[2];

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!reset) begin
                tcnt[m] = 0;
                cyc[m]  = 0;
            end else begin
                if (!prev_busy[m] && busy_o[m]) begin
                    tcnt[m] = 0;
                    cyc[m]  = 0;
                end else if (prev_busy[m]) begin
                    cyc[m]++;
                    if (tick) begin
                        tcnt[m]++;
                        if (tcnt[m] == 1) first_tick[m] = cyc[m];
                    end
                end
                if (done_o[m]) begin
                    done_cnt[m]++;
                    last_len[m] = tcnt[m];
                    last_err[m] = err_o[m];
                end
            end
            prev_busy[m] = busy_o[m];
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got %0d required %0d (t=%0t)", name, act, req, $time);
    endtask

    task automatic cycle_compare();
        logic [4:0] exp_v, act_v;
        string nm;
        forever begin
            @(negedge clk);
            for (int m = 0; m < 2; m++) begin
                if (m_active[m]) exp_v = {m_seq[m][m_idx[m]], 1'b1, 1'b0, m_err[m]};
                else             exp_v = {2'b10, 1'b0, m_done[m], m_err[m]};
                act_v = {scl_o[m], oe_o[m], busy_o[m], done_o[m], err_o[m]};
                nm = (m == 0) ? "cycle_chk{scl,oe,busy,done,err}" : "cycle_nochk{scl,oe,busy,done,err}";
                check(nm, act_v, exp_v);
            end
        end
    endtask

    task automatic do_start(input logic [7:0] d, input logic [7:0] r, input logic [7:0] w, input logic aligned);
        int n = 0;
        @(negedge clk); #2;
        while (tick !== aligned && n < 4 * TICK_DIV) begin
            @(negedge clk); #2;
            n++;
        end
        dev_addr = d; reg_addr = r; wr_data = w; start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_ticks(input int target, input string tag);
        int n = 0;
        while (tcnt[0] < target && n < CYC_LIMIT) begin
            @(negedge clk); #2;
            n++;
        end
        check(tag, tcnt[0], target);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge clk); #2;
            n++;
        end while (busy_o != 2'b00 && n < CYC_LIMIT);
        check(tag, busy_o, 0);
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int s0, p0, d0;
        fork
            cycle_compare();
        join_none

        #1 reset = 1'b0;
        #2;
        check("reset_scl", scl_o, 3);
        check("reset_sda_oe", oe_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_done", done_o, 0);
        check("reset_ack_err", err_o, 0);
        @(negedge clk); @(negedge clk); #2;
        reset = 1'b1;

        // Full write, all bytes ACKed
        nack_mask = 3'b000;
        s0 = start_seen; p0 = stop_seen; d0 = done_cnt[0];
        do_start(8'h42, 8'h12, 8'h80, 1'b0);
        wait_idle("t1_idle");
        check("t1_ticks", last_len[0], 116);
        check("t1_ack_err", last_err[0], 0);
        check("t1_rx_count", rx_n, 3);
        check("t1_rx0", rx_b[0], 8'h42);
        check("t1_rx1", rx_b[1], 8'h12);
        check("t1_rx2", rx_b[2], 8'h80);
        check("t1_start_cond", start_seen - s0, 1);
        check("t1_stop_cond", stop_seen - p0, 1);
        check("t1_done_count", done_cnt[0] - d0, 1);

        // Device address NACKed
        nack_mask = 3'b001;
        do_start(8'h42, 8'h12, 8'h80, 1'b0);
        wait_idle("t2_idle");
        check("t2_chk_ticks", last_len[0], 44);
        check("t2_chk_ack_err", last_err[0], 1);
        check("t2_chk_rx_count", rx_n, 1);
        check("t2_nochk_ticks", last_len[1], 116);
        check("t2_nochk_ack_err", last_err[1], 0);

        // Start with new data mid-transaction is ignored
        nack_mask = 3'b000;
        d0 = done_cnt[0];
        do_start(8'h42, 8'h12, 8'h80, 1'b0);
        wait_ticks(50, "t3_reach_tick50");
        dev_addr = 8'hA5; reg_addr = 8'h5A; wr_data = 8'h3C; start = 1'b1;
        @(negedge clk); #2;
        start = 1'b0;
        wait_idle("t3_idle");
        check("t3_done_count", done_cnt[0] - d0, 1);
        check("t3_ticks", last_len[0], 116);
        check("t3_rx0", rx_b[0], 8'h42);
        check("t3_rx1", rx_b[1], 8'h12);
        check("t3_rx2", rx_b[2], 8'h80);

        // Reset mid-transfer, then a fresh write
        do_start(8'h42, 8'h34, 8'h56, 1'b0);
        wait_ticks(30, "t4_reach_tick30");
        d0 = done_cnt[0];
        reset = 1'b0;
        #1;
        check("t4_rst_scl", scl_o, 3);
        check("t4_rst_sda_oe", oe_o, 0);
        check("t4_rst_busy", busy_o, 0);
        check("t4_rst_done", done_o, 0);
        repeat (3) @(negedge clk);
        #2;
        check("t4_no_done", done_cnt[0] - d0, 0);
        reset = 1'b1;
        do_start(8'h42, 8'h34, 8'h56, 1'b0);
        wait_idle("t4_idle");
        check("t4_ticks", last_len[0], 116);
        check("t4_ack_err", last_err[0], 0);
        check("t4_rx1", rx_b[1], 8'h34);
        check("t4_rx2", rx_b[2], 8'h56);

        // Start coincident with a tick
        do_start(8'h42, 8'h12, 8'h80, 1'b1);
        wait_idle("t5_idle");
        check("t5_start_phase0_cycles", first_tick[0], TICK_DIV);
        check("t5_ticks", last_len[0], 116);
        check("t5_nochk_ticks", last_len[1], 116);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
